epoch_gate: RTL
===============

Name: epoch_gate

Overview:
- Parametrised successor to the autoencoder's training-sample gate.
- Sits between the sample source and the training datapath, with a registered pass-through of `data_in`.
- Each epoch-delimiter code (SENTINEL) in the stream is replaced by REPLACE, and the epoch counter advances.
- After MAX_EPOCH delimiters the block freezes its output and raises `done` until restarted.
- New versus the previous gate: valid handshake, restart, epoch observability and a saturation flag.

Parameters:
- DATA_W, 16: sample width in bits.
- SENTINEL, 342: epoch-delimiter code; compared against all DATA_W bits.
- REPLACE, 0: value emitted in place of SENTINEL.
- MAX_EPOCH, 10000: number of delimiters that ends training. Must be ≥1; otherwise elaboration error.
- CNT_W, 14: epoch counter width. Elaboration error if 2^CNT_W−1 < MAX_EPOCH.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- restart  input  1  synchronous clear; returns the block to RUN for a new training session.
- in_valid  input  1  `data_in` qualifier.
- data_in  input  DATA_W  incoming sample.
- out_valid  output  1  `data_out` qualifier.
- data_out  output  DATA_W  gated sample.
- epoch_pulse  output  1  one-cycle strobe, coincident with the `out_valid` beat carrying REPLACE.
- epoch_cnt  output  CNT_W  delimiters consumed so far.
- done  output  1  high while in DONE.

Behaviour:
- Reset (rst=1, asynchronous):
  - state=RUN
  - data_out=0, out_valid=0, epoch_pulse=0, epoch_cnt=0, done=0
- States: RUN, DONE. Encoded in a 1-bit state register.
- RUN, in_valid=1, data_in≠SENTINEL:
  - next edge: data_out←data_in, out_valid←1, epoch_pulse←0.
- RUN, in_valid=1, data_in=SENTINEL:
  - next edge: data_out←REPLACE, out_valid←1, epoch_pulse←1, epoch_cnt←epoch_cnt+1.
- RUN, in_valid=0:
  - out_valid←0, epoch_pulse←0.
  - data_out holds its last value; epoch_cnt unchanged.
- Latency: exactly 1 cycle from the in_valid beat to the out_valid beat. No backpressure; the block accepts every cycle.
- RUN→DONE: on the same edge that loads epoch_cnt=MAX_EPOCH.
  - The terminating delimiter is still emitted as REPLACE with out_valid=1 and epoch_pulse=1 on that edge.
  - done=1 from that edge.
- DONE:
  - All inputs except restart/rst are ignored.
  - out_valid=0, epoch_pulse=0.
  - data_out holds REPLACE; epoch_cnt holds MAX_EPOCH; done=1.
- restart=1 (any state):
  - next edge: state=RUN, epoch_cnt=0, done=0, out_valid=0, epoch_pulse=0, data_out=0.
  - restart has priority over a simultaneous in_valid beat; that beat is dropped.
- epoch_cnt never wraps: it saturates at MAX_EPOCH via the DONE state.
- Comparison is exact equality on the full DATA_W bits. No sign interpretation.
- REPLACE=SENTINEL is legal; the count still advances.
- rst mid-stream: asynchronous clear to the reset values above. Any pending output beat is lost.
- Outputs are all registered; there are no combinational paths from input to output.

Decomposition:
- Shared package `ae_pkg` holds:
  - default DATA_W
  - SENTINEL code 342
  - default MAX_EPOCH
  - the RUN/DONE state encoding, also used by the training controller
- One natural sub-module: `sat_counter`.
  - Parametrised CNT_W/MAX, with inc, clr and async rst inputs.
  - Outputs: count and at_max.
  - epoch_gate instantiates it for epoch_cnt; at_max drives the RUN→DONE transition.

Test Plan (MAX_EPOCH=3 unless stated):
1. Reset, then stream 5,7,9 with in_valid=1 → out_valid beats carry 5,7,9 one cycle later; epoch_pulse=0; epoch_cnt=0.
2. Stream 5,342,6 → outputs 5,0,6; epoch_pulse high only on the 0 beat; epoch_cnt 0→1.
3. Three 342 beats interleaved with 1,2, then 8,9 → third delimiter output as 0 with done=1 on the same edge. 8 and 9 produce no out_valid; epoch_cnt stays 3; data_out stays 0.
4. In DONE, assert restart, then stream 4,342 → outputs 4,0; epoch_cnt=1; done=0.
5. restart asserted in the same cycle as in_valid=1, data_in=342 → no output beat; epoch_cnt=0.
6. Assert rst asynchronously between edges with epoch_cnt=2 → all outputs cleared immediately, without waiting for clk. After release, stream 7 → output 7.

Source files
------------

// File: rtl/ae_pkg.sv
`default_nettype none
// ============================================================================
// ae_pkg : shared autoencoder constants and the RUN/DONE state encoding
// Revision: 1.0
// ============================================================================
package ae_pkg;

   localparam int unsigned DATA_W_DEF    = 16;
   localparam int unsigned SENTINEL_CODE = 342;
   localparam int unsigned MAX_EPOCH_DEF = 10000;
   localparam int unsigned CNT_W_DEF     = 14;

   typedef enum logic [0:0] {
      ST_RUN  = 1'b0,
      ST_DONE = 1'b1
   } ae_state_t;

   // True when a CNT_W-bit counter can hold the value max without wrapping.
   function automatic bit cnt_fits(input int unsigned w, input int unsigned max);
      longint unsigned cap;
      if (w >= 32) return 1'b1;
      cap = (64'd1 << w) - 64'd1;
      return (cap >= 64'(max));
   endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// sat_counter : up-counter that stops at MAX, with synchronous clear
// Revision: 1.0
// ============================================================================
module sat_counter
   import ae_pkg::*;
#(
   parameter int unsigned CNT_W = CNT_W_DEF,
   parameter int unsigned MAX   = MAX_EPOCH_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] count,
   output logic             at_max
);

   localparam logic [CNT_W-1:0] c_max    = CNT_W'(MAX);
   localparam logic [CNT_W-1:0] c_max_m1 = CNT_W'(MAX - 1);
   localparam logic [CNT_W-1:0] c_one    = CNT_W'(1);

   logic [CNT_W-1:0] r_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
      end else if (clr) begin
         r_count <= '0;
      end else if (inc && (r_count != c_max)) begin
         r_count <= r_count + c_one;
      end
   end

   assign count = r_count;

   // Looks one edge ahead: high when already saturated or when this cycle's
   // increment lands on MAX, so a controller can change state on that edge.
   assign at_max = (r_count == c_max) || (inc && !clr && (r_count == c_max_m1));

endmodule
`default_nettype wire

// File: rtl/epoch_gate.sv
`default_nettype none
// ============================================================================
// epoch_gate : registered sample gate that swaps epoch delimiters, counts
//              epochs and freezes after MAX_EPOCH of them until restarted
// Revision: 1.0
// ============================================================================
module epoch_gate
   import ae_pkg::*;
#(
   parameter int unsigned              DATA_W    = DATA_W_DEF,
   parameter logic [DATA_W-1:0]        SENTINEL  = DATA_W'(SENTINEL_CODE),
   parameter logic [DATA_W-1:0]        REPLACE   = '0,
   parameter int unsigned              MAX_EPOCH = MAX_EPOCH_DEF,
   parameter int unsigned              CNT_W     = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              restart,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] data_in,
   output logic              out_valid,
   output logic [DATA_W-1:0] data_out,
   output logic              epoch_pulse,
   output logic [CNT_W-1:0]  epoch_cnt,
   output logic              done
);

   generate
      if (MAX_EPOCH < 1) begin : g_bad_max_epoch
         $error("epoch_gate: MAX_EPOCH must be at least 1");
      end
      if (!cnt_fits(CNT_W, MAX_EPOCH)) begin : g_bad_cnt_w
         $error("epoch_gate: CNT_W too narrow to hold MAX_EPOCH");
      end
   endgenerate

   ae_state_t         r_state;
   ae_state_t         w_state_d;
   logic [DATA_W-1:0] r_data_out;
   logic [DATA_W-1:0] w_data_d;
   logic              r_out_valid;
   logic              w_valid_d;
   logic              r_epoch_pulse;
   logic              w_pulse_d;

   logic              w_is_delim;
   logic              w_inc;
   logic              w_at_max;

   assign w_is_delim = (data_in == SENTINEL);
   assign w_inc      = (r_state == ST_RUN) && in_valid && w_is_delim && !restart;

   sat_counter #(
      .CNT_W (CNT_W),
      .MAX   (MAX_EPOCH)
   ) u_epoch_counter (
      .clk    (clk),
      .rst    (rst),
      .inc    (w_inc),
      .clr    (restart),
      .count  (epoch_cnt),
      .at_max (w_at_max)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= ST_RUN;
         r_data_out    <= '0;
         r_out_valid   <= 1'b0;
         r_epoch_pulse <= 1'b0;
      end else begin
         r_state       <= w_state_d;
         r_data_out    <= w_data_d;
         r_out_valid   <= w_valid_d;
         r_epoch_pulse <= w_pulse_d;
      end
   end

   always_comb begin
      w_state_d = r_state;
      w_data_d  = r_data_out;
      w_valid_d = 1'b0;
      w_pulse_d = 1'b0;
      if (restart) begin
         // A beat arriving alongside restart is dropped on purpose.
         w_state_d = ST_RUN;
         w_data_d  = '0;
      end else begin
         case (r_state)
            ST_RUN: begin
               if (in_valid) begin
                  w_valid_d = 1'b1;
                  if (w_is_delim) begin
                     w_data_d  = REPLACE;
                     w_pulse_d = 1'b1;
                     if (w_at_max) begin
                        w_state_d = ST_DONE;
                     end
                  end else begin
                     w_data_d = data_in;
                  end
               end
            end
            ST_DONE: begin
               // Frozen: data_out keeps REPLACE, count stays at MAX_EPOCH.
            end
         endcase
      end
   end

   assign out_valid   = r_out_valid;
   assign data_out    = r_data_out;
   assign epoch_pulse = r_epoch_pulse;
   assign done        = (r_state == ST_DONE);

endmodule
`default_nettype wire
